// File: rtl/cmd_res_uart_tx_pkg.sv
// Shared constants and types for the command-result UART return path.
// Frame layout: SYNC, result bytes LSB first, then an XOR checksum.
package cmd_res_uart_tx_pkg;

  localparam int         CMD_RES_W     = 32;
  localparam int         FRAME_BYTES   = 6;
  localparam int         BYTE_IDX_W    = $clog2(FRAME_BYTES);
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_DRAIN
  } seq_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0]           sync,
                                           input logic [CMD_RES_W-1:0] word);
    return sync ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
  endfunction

endpackage

// File: rtl/cmd_res_uart_tx_if.sv
// Valid/ready handshake carrying one command result word.
interface cmd_res_uart_tx_if;
  import cmd_res_uart_tx_pkg::*;

  logic [CMD_RES_W-1:0] res_data;
  logic                 res_valid;
  logic                 res_ready;

  modport master (output res_data, output res_valid, input  res_ready);
  modport slave  (input  res_data, input  res_valid, output res_ready);

endinterface

// File: rtl/cmd_res_uart_tx_byte.sv
// 8N1 byte serializer with byte/valid/ready input; owns baud and bit counters.
// state    | meaning
// TX_IDLE  | line idle high, waiting for a byte
// TX_START | driving start bit (0)
// TX_DATA  | driving data bits LSB first
// TX_STOP  | driving stop bit (1); may chain straight into the next byte
module uart_tx_byte
  import cmd_res_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868  // minimum 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       stop_near_end,
  output logic       txd
);

  localparam int            BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PEN  = BAUD_W'(CLKS_PER_BIT - 2);

  tx_state_t         state_q, state_n;
  logic [BAUD_W-1:0] baud_q, baud_n;
  logic [2:0]        bit_idx_q, bit_idx_n;
  logic [7:0]        shift_q, shift_n;
  logic              txd_q, txd_n;
  logic              baud_end;

  assign baud_end      = (baud_q == BAUD_LAST);
  assign byte_ready    = (state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_end);
  // One cycle before the final stop cycle; lets the sequencer reopen early.
  assign stop_near_end = (state_q == TX_STOP) && (baud_q == BAUD_PEN);
  assign txd           = txd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_idx_q <= bit_idx_n;
      shift_q   <= shift_n;
      txd_q     <= txd_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    baud_n    = baud_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    txd_n     = txd_q;
    case (state_q)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (byte_valid) begin
          state_n = TX_START;
          shift_n = byte_data;
          baud_n  = '0;
          txd_n   = 1'b0;
        end
      end
      TX_START: begin
        if (baud_end) begin
          state_n   = TX_DATA;
          baud_n    = '0;
          bit_idx_n = '0;
          txd_n     = shift_q[0];
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx_q == 3'd7) begin
            state_n = TX_STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx_q + 1'b1;
            shift_n   = {1'b0, shift_q[7:1]};
            txd_n     = shift_q[1];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (byte_valid) begin
            state_n = TX_START;
            shift_n = byte_data;
            txd_n   = 1'b0;
          end else begin
            state_n = TX_IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: begin
        state_n = TX_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cmd_res_uart_tx.sv
// Command result return path: latches a 32-bit result and sends it as a
// six-byte 8N1 frame (SYNC, b0..b3, XOR checksum) on the host UART.
// state     | meaning
// SEQ_IDLE  | res_ready high, waiting for a result word
// SEQ_SEND  | offering frame bytes to the serializer
// SEQ_DRAIN | last byte handed off, waiting for its stop bit to finish
module cmd_res_uart_tx
  import cmd_res_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  cmd_res_uart_tx_if.slave   res_if,
  output logic               uart_txd,
  output logic               busy
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);

  seq_state_t            seq_q, seq_n;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_n;
  logic [CMD_RES_W-1:0]  res_q, res_n;
  logic                  ready_q, ready_n;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  byte_hs;
  logic                  stop_near_end;

  assign res_if.res_ready = ready_q;
  assign busy             = (seq_q != SEQ_IDLE);
  assign byte_valid       = (seq_q == SEQ_SEND);
  assign byte_hs          = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q      <= SEQ_IDLE;
      byte_idx_q <= '0;
      res_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      seq_q      <= seq_n;
      byte_idx_q <= byte_idx_n;
      res_q      <= res_n;
      ready_q    <= ready_n;
    end
  end

  always_comb begin
    seq_n      = seq_q;
    byte_idx_n = byte_idx_q;
    res_n      = res_q;
    ready_n    = ready_q;
    case (seq_q)
      SEQ_IDLE: begin
        ready_n = 1'b1;
        if (res_if.res_valid && ready_q) begin
          ready_n    = 1'b0;
          res_n      = res_if.res_data;
          byte_idx_n = '0;
          seq_n      = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        if (byte_hs) begin
          if (byte_idx_q == LAST_BYTE) begin
            seq_n = SEQ_DRAIN;
          end else begin
            byte_idx_n = byte_idx_q + 1'b1;
          end
        end
      end
      SEQ_DRAIN: begin
        // Reopening here means a held res_valid is taken exactly as the
        // last stop bit ends, leaving one idle-high cycle before the next SYNC.
        if (stop_near_end) begin
          seq_n      = SEQ_IDLE;
          ready_n    = 1'b1;
          byte_idx_n = '0;
        end
      end
      default: begin
        seq_n   = SEQ_IDLE;
        ready_n = 1'b0;
      end
    endcase
  end

  always_comb begin
    byte_data = SYNC_BYTE;
    case (byte_idx_q)
      BYTE_IDX_W'(1): byte_data = res_q[7:0];
      BYTE_IDX_W'(2): byte_data = res_q[15:8];
      BYTE_IDX_W'(3): byte_data = res_q[23:16];
      BYTE_IDX_W'(4): byte_data = res_q[31:24];
      BYTE_IDX_W'(5): byte_data = frame_chk(SYNC_BYTE, res_q);
      default:        byte_data = SYNC_BYTE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk          (clk),
    .reset        (reset),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .stop_near_end(stop_near_end),
    .txd          (uart_txd)
  );

endmodule

// File: tb/tb_cmd_res_uart_tx.sv
// Directed bench for cmd_res_uart_tx with CLKS_PER_BIT=4 (240-cycle frames).
module tb_cmd_res_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_txd;
  logic busy;

  cmd_res_uart_tx_if res_if ();

  cmd_res_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .res_if  (res_if),
    .uart_txd(uart_txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic wave [0:240];
  logic rdy  [0:240];
  logic busy_s;

  typedef struct {
    logic [31:0]     word;
    bit              noise;
    logic [5:0][7:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic present(input logic [31:0] w, output int acc);
    res_if.res_data  = w;
    res_if.res_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (res_if.res_ready === 1'b1) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no res_ready expected res_ready within 2000 cycles");
      acc = cyc;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic capture(input bit noise);
    for (int off = 0; off <= 240; off++) begin
      if (off > 0) @(negedge clk);
      wave[off] = uart_txd;
      rdy[off]  = res_if.res_ready;
      if (off == 1) busy_s = busy;
      if (noise) begin
        if (off >= 1 && off < 230) begin
          res_if.res_valid = 1'($urandom_range(0, 1));
          res_if.res_data  = $urandom;
        end else if (off >= 230) begin
          res_if.res_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [5:0][7:0] exp);
    int bad_frm;
    int bad_stop;
    int rdy_hi;
    logic [7:0] b;
    check($sformatf("%s start_latency", tag), {30'd0, wave[0], wave[1]}, 32'h2);
    check($sformatf("%s busy", tag), {31'd0, busy_s}, 32'h1);
    bad_frm = 0;
    for (int k = 0; k < 6; k++) begin
      if (wave[2 + 40*k] !== 1'b0) bad_frm++;
      if (wave[2 + 40*k + 36] !== 1'b1) bad_frm++;
    end
    check($sformatf("%s framing_errs", tag), bad_frm, 0);
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 8; j++) b[j] = wave[2 + 40*k + 4*(j+1)];
      check($sformatf("%s byte%0d", tag, k), {24'd0, b}, {24'd0, exp[k]});
    end
    bad_stop = 0;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) if (wave[1 + 40*k + 36 + c] !== 1'b1) bad_stop++;
      if (k < 5 && wave[1 + 40*k + 40] !== 1'b0) bad_stop++;
    end
    check($sformatf("%s stop_len_errs", tag), bad_stop, 0);
    check($sformatf("%s ready_rise", tag), {30'd0, rdy[239], rdy[240]}, 32'h1);
    rdy_hi = 0;
    for (int t = 1; t < 240; t++) if (rdy[t] !== 1'b0) rdy_hi++;
    check($sformatf("%s ready_low_cycles", tag), rdy_hi, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int zeros;

    vecs[0] = '{32'h12345678, 1'b0, {8'hAD, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5}};
    vecs[1] = '{32'h00000000, 1'b0, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[2] = '{32'hCAFE0042, 1'b1, {8'hD3, 8'hCA, 8'hFE, 8'h00, 8'h42, 8'hA5}};
    vecs[3] = '{32'hFFFFFFFF, 1'b0, {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5}};

    res_if.res_valid = 1'b0;
    res_if.res_data  = '0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_txd",   {31'd0, uart_txd}, 32'h1);
    check("rst_ready", {31'd0, res_if.res_ready}, 32'h0);
    check("rst_busy",  {31'd0, busy}, 32'h0);
    reset = 1'b1;
    check("ready_before_edge", {31'd0, res_if.res_ready}, 32'h0);
    @(negedge clk);
    check("ready_after_edge", {31'd0, res_if.res_ready}, 32'h1);

    for (int i = 0; i < 4; i++) begin
      present(vecs[i].word, acc);
      res_if.res_valid = 1'b0;
      capture(vecs[i].noise);
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Back-to-back with res_valid held high across the frame boundary.
    present(32'hDEADBEEF, acc);
    res_if.res_data = 32'h00000001;
    capture(1'b0);
    check_frame("b2b0", {8'h87, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5});
    present(32'h00000001, acc2);
    check("b2b_accept_gap", acc2 - acc, 241);
    res_if.res_valid = 1'b0;
    capture(1'b0);
    check_frame("b2b1", {8'hA4, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA5});

    // Reset 100 cycles into a frame, between clock edges.
    present(32'h00000000, acc);
    res_if.res_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_reset_txd", {31'd0, uart_txd}, 32'h0);
    #1 reset = 1'b0;
    #1;
    check("async_reset_txd",  {31'd0, uart_txd}, 32'h1);
    check("async_reset_busy", {31'd0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    zeros = 0;
    repeat (6) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) zeros++;
    end
    check("no_resend_after_reset", zeros, 0);
    present(32'h0000FFFF, acc);
    res_if.res_valid = 1'b0;
    capture(1'b0);
    check_frame("post_reset", {8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hA5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
